intersect_unit: RTL and testbench

Two-way sparse coordinate intersector that sits directly downstream of two `fiber_access_16` read scanners. It consumes each scanner's `(coord_out, pos_out)` stream pair and emits only the coordinates present in both fibers, together with the matching position from each side. Stop and done tokens pass through, aligned. The output stream feeds a downstream value-fetch `fiber_access_16` in lookup mode.

---
 rtl/intersect_unit.sv | 110 +++++++++++
 tb/tb_intersect_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersect_unit.sv
// intersect_unit: two-way sparse coordinate intersector for a pair of scanner (coord,pos) streams
// Inputs : clk, rst_n (async, active-high), clk_en, flush, tile_en,
//          coord_in_{0,1}/pos_in_{0,1} token lanes with valid, ready out
// Outputs: coord_out/pos_out_{0,1} triple with per-output valid, ready in,
//          match_count (data matches this transaction), error (sticky control mismatch)
module intersect_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W:0]   coord_in_0,
  input  logic              coord_in_0_valid,
  output logic              coord_in_0_ready,
  input  logic [DATA_W:0]   coord_in_1,
  input  logic              coord_in_1_valid,
  output logic              coord_in_1_ready,
  input  logic [DATA_W:0]   pos_in_0,
  input  logic              pos_in_0_valid,
  output logic              pos_in_0_ready,
  input  logic [DATA_W:0]   pos_in_1,
  input  logic              pos_in_1_valid,
  output logic              pos_in_1_ready,
  output logic [DATA_W:0]   coord_out,
  output logic              coord_out_valid,
  input  logic              coord_out_ready,
  output logic [DATA_W:0]   pos_out_0,
  output logic              pos_out_0_valid,
  input  logic              pos_out_0_ready,
  output logic [DATA_W:0]   pos_out_1,
  output logic              pos_out_1_valid,
  input  logic              pos_out_1_ready,
  output logic [15:0]       match_count,
  output logic              error
);
  logic [DATA_W:0] r_c, r_p0, r_p1;
  logic [2:0]      r_pend;
  logic [15:0]     r_cnt;
  logic            r_err;
  logic [2:0]      w_vld, w_acc;
  logic            w_en, w_can, w_go, w_d0, w_d1, w_dn0, w_dn1, w_st0, w_st1;
  logic            w_same, w_lt, w_gt, w_pop0, w_pop1, w_emit, w_bad;
  // handshakes are only honoured while state can actually advance, so no
  // acceptance or pop is ever lost during a hold or a flush
  assign w_en  = tile_en & clk_en & ~flush;
  assign w_vld = r_pend & {3{w_en}};
  assign w_acc = w_vld & {pos_out_1_ready, pos_out_0_ready, coord_out_ready};
  assign w_can = ~|(r_pend & ~w_acc);
  assign w_go  = w_en & w_can & coord_in_0_valid & pos_in_0_valid & coord_in_1_valid & pos_in_1_valid;
  assign w_d0  = ~coord_in_0[DATA_W];
  assign w_d1  = ~coord_in_1[DATA_W];
  assign w_dn0 = coord_in_0[DATA_W] & (coord_in_0[9:8] == 2'b01);
  assign w_dn1 = coord_in_1[DATA_W] & (coord_in_1[9:8] == 2'b01);
  assign w_st0 = ~w_d0 & ~w_dn0;
  assign w_st1 = ~w_d1 & ~w_dn1;
  assign w_lt  = coord_in_0[DATA_W-1:0] < coord_in_1[DATA_W-1:0];
  assign w_gt  = coord_in_1[DATA_W-1:0] < coord_in_0[DATA_W-1:0];
  // matching heads of the same kind: emit and pop both lanes
  assign w_same = (w_d0 & w_d1 & ~w_lt & ~w_gt) | (w_dn0 & w_dn1) |
                  (w_st0 & w_st1 & (coord_in_0[7:0] == coord_in_1[7:0]));
  // mismatched control pair: stop lanes pop, a done waits for its partner
  assign w_pop0 = w_go & (w_same | (w_d0 & (~w_d1 | w_lt)) | (~w_d0 & ~w_d1 & ~w_dn0));
  assign w_pop1 = w_go & (w_same | (w_d1 & (~w_d0 | w_gt)) | (~w_d0 & ~w_d1 & ~w_dn1));
  assign w_emit = w_go & w_same;
  assign w_bad  = w_go & ~w_d0 & ~w_d1 & ~w_same;
  assign coord_in_0_ready = w_pop0;
  assign pos_in_0_ready   = w_pop0;
  assign coord_in_1_ready = w_pop1;
  assign pos_in_1_ready   = w_pop1;
  assign coord_out        = r_c;
  assign pos_out_0        = r_p0;
  assign pos_out_1        = r_p1;
  assign coord_out_valid  = w_vld[0];
  assign pos_out_0_valid  = w_vld[1];
  assign pos_out_1_valid  = w_vld[2];
  assign match_count      = r_cnt;
  assign error            = r_err;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_c    <= '0;
      r_p0   <= '0;
      r_p1   <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (flush) begin
      r_c    <= '0;
      r_p0   <= '0;
      r_p1   <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (tile_en & clk_en) begin
      r_pend <= w_emit ? 3'b111 : r_pend & ~w_acc;
      if (w_emit) begin
        r_c  <= coord_in_0;
        r_p0 <= w_d0 ? pos_in_0 : coord_in_0;
        r_p1 <= w_d0 ? pos_in_1 : coord_in_0;
      end
      if (w_emit & w_dn0)
        r_cnt <= '0;
      else if (w_emit & w_d0 & ~&r_cnt)
        r_cnt <= r_cnt + 16'd1;
      if (w_bad)
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_intersect_unit.sv
// tb_intersect_unit: randomized and directed checks of intersect_unit against a set-level model
module tb_intersect_unit;
  localparam logic [16:0] D = 17'h10100;
  logic clk = 1'b0;
  logic rst_n, clk_en, flush, tile_en;
  logic [16:0] coord_in_0, coord_in_1, pos_in_0, pos_in_1;
  logic coord_in_0_valid, coord_in_1_valid, pos_in_0_valid, pos_in_1_valid;
  logic coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready;
  logic [16:0] coord_out, pos_out_0, pos_out_1;
  logic coord_out_valid, pos_out_0_valid, pos_out_1_valid;
  logic coord_out_ready, pos_out_0_ready, pos_out_1_ready;
  logic [15:0] match_count;
  logic error;
  int checks = 0;
  int failures = 0;
  logic [16:0] l0c[$], l0p[$], l1c[$], l1p[$];
  logic [16:0] ec[$], ep0[$], ep1[$], qc[$], qp0[$], qp1[$];
  int ecnt[$], qcnt[$];
  bit eerr[$], qerr[$];
  bit m_err, timed_out;
  int m_cnt, stall_viol, pair_viol;

  always #5 clk = ~clk;

  intersect_unit #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .coord_in_0(coord_in_0), .coord_in_0_valid(coord_in_0_valid), .coord_in_0_ready(coord_in_0_ready),
    .coord_in_1(coord_in_1), .coord_in_1_valid(coord_in_1_valid), .coord_in_1_ready(coord_in_1_ready),
    .pos_in_0(pos_in_0), .pos_in_0_valid(pos_in_0_valid), .pos_in_0_ready(pos_in_0_ready),
    .pos_in_1(pos_in_1), .pos_in_1_valid(pos_in_1_valid), .pos_in_1_ready(pos_in_1_ready),
    .coord_out(coord_out), .coord_out_valid(coord_out_valid), .coord_out_ready(coord_out_ready),
    .pos_out_0(pos_out_0), .pos_out_0_valid(pos_out_0_valid), .pos_out_0_ready(pos_out_0_ready),
    .pos_out_1(pos_out_1), .pos_out_1_valid(pos_out_1_valid), .pos_out_1_ready(pos_out_1_ready),
    .match_count(match_count), .error(error)
  );

  function automatic logic [16:0] stp(int l);
    return {9'h100, 8'(l)};
  endfunction

  task automatic idle_inputs();
    coord_in_0 = '0; pos_in_0 = '0; coord_in_1 = '0; pos_in_1 = '0;
    coord_in_0_valid = 0; pos_in_0_valid = 0; coord_in_1_valid = 0; pos_in_1_valid = 0;
  endtask

  task automatic clr();
    l0c.delete(); l0p.delete(); l1c.delete(); l1p.delete();
    ec.delete(); ep0.delete(); ep1.delete(); ecnt.delete(); eerr.delete();
    m_err = 0; m_cnt = 0;
  endtask

  task automatic tok(int lane, logic [16:0] c, logic [16:0] p);
    if (lane == 0) begin l0c.push_back(c); l0p.push_back(p); end
    else begin l1c.push_back(c); l1p.push_back(p); end
  endtask

  // model: every emitted data coordinate counts as a match; done resets the count
  task automatic exp_out(logic [16:0] c, logic [16:0] p0, logic [16:0] p1);
    if (!c[16]) m_cnt++;
    ec.push_back(c); ep0.push_back(p0); ep1.push_back(p1);
    ecnt.push_back(c == D ? 0 : m_cnt); eerr.push_back(m_err);
    if (c == D) m_cnt = 0;
  endtask

  task automatic add_isect();
    tok(0, 17'd1, 17'd10); tok(0, 17'd3, 17'd11); tok(0, 17'd5, 17'd12);
    tok(0, stp(0), stp(0)); tok(0, D, D);
    tok(1, 17'd3, 17'd20); tok(1, 17'd4, 17'd21); tok(1, 17'd5, 17'd22);
    tok(1, stp(0), stp(0)); tok(1, D, D);
    exp_out(17'd3, 17'd11, 17'd20); exp_out(17'd5, 17'd12, 17'd22);
    exp_out(stp(0), stp(0), stp(0)); exp_out(D, D, D);
  endtask

  // random fibers built as sets: a coordinate lands in lane 0, lane 1, both or neither
  task automatic add_rand(int nseg, bit mism);
    for (int s = 0; s < nseg; s++) begin
      int p0 = $urandom_range(0, 500);
      int p1 = $urandom_range(0, 500);
      int a = $urandom_range(0, 3);
      int b;
      logic [16:0] c;
      for (int v = 0; v < 12; v++) begin
        int r = $urandom_range(0, 3);
        c = 17'(v * 8 + $urandom_range(0, 7));
        if (r < 2) tok(0, c, 17'(p0 + v));
        if (r == 0 || r == 2) tok(1, c, 17'(p1 + v));
        if (r == 0) exp_out(c, 17'(p0 + v), 17'(p1 + v));
      end
      b = (mism && s == 0) ? a + 1 : a;
      tok(0, stp(a), stp(a)); tok(1, stp(b), stp(b));
      if (a == b) exp_out(stp(a), stp(a), stp(a)); else m_err = 1;
    end
    tok(0, D, D); tok(1, D, D); exp_out(D, D, D);
  endtask

  task automatic run(int maxcyc, bit rnd_p1, bit bub);
    int i0 = 0;
    int i1 = 0;
    int extra = -1;
    qc.delete(); qp0.delete(); qp1.delete(); qcnt.delete(); qerr.delete();
    stall_viol = 0; pair_viol = 0; timed_out = 1;
    for (int cyc = 0; cyc < maxcyc; cyc++) begin
      @(posedge clk); #1;
      coord_in_0 = i0 < l0c.size() ? l0c[i0] : '0;
      pos_in_0   = i0 < l0c.size() ? l0p[i0] : '0;
      coord_in_0_valid = i0 < l0c.size() && (!bub || $urandom_range(0, 3) != 0);
      pos_in_0_valid   = i0 < l0c.size() && (!bub || $urandom_range(0, 3) != 0);
      coord_in_1 = i1 < l1c.size() ? l1c[i1] : '0;
      pos_in_1   = i1 < l1c.size() ? l1p[i1] : '0;
      coord_in_1_valid = i1 < l1c.size() && (!bub || $urandom_range(0, 3) != 0);
      pos_in_1_valid   = i1 < l1c.size() && (!bub || $urandom_range(0, 3) != 0);
      coord_out_ready = 1; pos_out_0_ready = 1;
      pos_out_1_ready = rnd_p1 ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (coord_out_valid && coord_out_ready) begin
        qc.push_back(coord_out); qcnt.push_back(int'(match_count)); qerr.push_back(error);
      end
      if (pos_out_0_valid && pos_out_0_ready) qp0.push_back(pos_out_0);
      if (pos_out_1_valid && pos_out_1_ready) qp1.push_back(pos_out_1);
      if ((coord_in_0_ready || coord_in_1_ready) && pos_out_1_valid && !pos_out_1_ready) stall_viol++;
      if (coord_in_0_ready != pos_in_0_ready || coord_in_1_ready != pos_in_1_ready) pair_viol++;
      if (coord_in_0_ready) i0++;
      if (coord_in_1_ready) i1++;
      if (extra < 0 && i0 == l0c.size() && i1 == l1c.size() && qc.size() >= ec.size() &&
          qp0.size() >= ep0.size() && qp1.size() >= ep1.size()) extra = 4;
      if (extra == 0) begin timed_out = 0; break; end
      if (extra > 0) extra--;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1; clk_en = 1; flush = 0; tile_en = 1; idle_inputs();
    coord_out_ready = 1; pos_out_0_ready = 1; pos_out_1_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({coord_out_valid, pos_out_0_valid, pos_out_1_valid, error} !== 4'b0 || match_count !== 16'd0 ||
        coord_out !== 17'd0 || pos_out_0 !== 17'd0 || pos_out_1 !== 17'd0) begin
      failures++;
      $display("FAIL reset got v=%b%b%b err=%b cnt=%0d out=%h/%h/%h exp all zero",
               coord_out_valid, pos_out_0_valid, pos_out_1_valid, error, match_count, coord_out, pos_out_0, pos_out_1);
    end
    rst_n = 0;
  endtask

  task automatic test_intersection();
    clr(); add_isect(); run(200, 0, 0);
    checks++;
    if (timed_out || qc.size() != ec.size() || qp0.size() != ep0.size() || qp1.size() != ep1.size()) begin
      failures++;
      $display("FAIL isect_len got %0d/%0d/%0d timeout=%b exp %0d", qc.size(), qp0.size(), qp1.size(), timed_out, ec.size());
    end
    for (int i = 0; i < ec.size(); i++) begin
      checks++;
      if (qc[i] !== ec[i] || qp0[i] !== ep0[i] || qp1[i] !== ep1[i] || qcnt[i] != ecnt[i] || qerr[i] !== eerr[i]) begin
        failures++;
        $display("FAIL isect[%0d] got %h %h %h cnt=%0d err=%b exp %h %h %h cnt=%0d err=%b", i,
                 qc[i], qp0[i], qp1[i], qcnt[i], qerr[i], ec[i], ep0[i], ep1[i], ecnt[i], eerr[i]);
      end
    end
    checks++;
    if (match_count !== 16'd0 || pair_viol != 0) begin
      failures++;
      $display("FAIL isect_end got cnt=%0d pair_viol=%0d exp 0 0", match_count, pair_viol);
    end
  endtask

  task automatic test_empty();
    clr();
    tok(0, 17'd0, 17'd30); tok(0, 17'd2, 17'd31); tok(0, stp(0), stp(0)); tok(0, D, D);
    tok(1, 17'd1, 17'd40); tok(1, 17'd3, 17'd41); tok(1, stp(0), stp(0)); tok(1, D, D);
    exp_out(stp(0), stp(0), stp(0)); exp_out(D, D, D);
    run(200, 0, 0);
    checks++;
    if (timed_out || qc.size() != ec.size() || qp0.size() != ep0.size() || qp1.size() != ep1.size()) begin
      failures++;
      $display("FAIL empty_len got %0d/%0d/%0d timeout=%b exp %0d", qc.size(), qp0.size(), qp1.size(), timed_out, ec.size());
    end
    for (int i = 0; i < ec.size(); i++) begin
      checks++;
      if (qc[i] !== ec[i] || qp0[i] !== ep0[i] || qp1[i] !== ep1[i] || qcnt[i] != ecnt[i]) begin
        failures++;
        $display("FAIL empty[%0d] got %h %h %h cnt=%0d exp %h %h %h cnt=%0d", i,
                 qc[i], qp0[i], qp1[i], qcnt[i], ec[i], ep0[i], ep1[i], ecnt[i]);
      end
    end
  endtask

  task automatic test_skewed();
    clr(); add_isect(); run(400, 1, 0);
    checks++;
    if (timed_out || qc.size() != ec.size() || qp0.size() != ep0.size() || qp1.size() != ep1.size()) begin
      failures++;
      $display("FAIL skew_len got %0d/%0d/%0d timeout=%b exp %0d", qc.size(), qp0.size(), qp1.size(), timed_out, ec.size());
    end
    for (int i = 0; i < ec.size(); i++) begin
      checks++;
      if (qc[i] !== ec[i] || qp0[i] !== ep0[i] || qp1[i] !== ep1[i] || qcnt[i] != ecnt[i]) begin
        failures++;
        $display("FAIL skew[%0d] got %h %h %h cnt=%0d exp %h %h %h cnt=%0d", i,
                 qc[i], qp0[i], qp1[i], qcnt[i], ec[i], ep0[i], ep1[i], ecnt[i]);
      end
    end
    checks++;
    if (stall_viol != 0 || pair_viol != 0) begin
      failures++;
      $display("FAIL skew_stall got stall_viol=%0d pair_viol=%0d exp 0 0", stall_viol, pair_viol);
    end
  endtask

  task automatic test_stop_mismatch();
    clr();
    tok(0, 17'd1, 17'd5); tok(0, stp(0), stp(0)); tok(0, D, D);
    tok(1, 17'd1, 17'd7); tok(1, stp(1), stp(1)); tok(1, D, D);
    exp_out(17'd1, 17'd5, 17'd7); m_err = 1; exp_out(D, D, D);
    run(200, 0, 0);
    checks++;
    if (timed_out || qc.size() != ec.size() || qp0.size() != ep0.size() || qp1.size() != ep1.size()) begin
      failures++;
      $display("FAIL mism_len got %0d/%0d/%0d timeout=%b exp %0d", qc.size(), qp0.size(), qp1.size(), timed_out, ec.size());
    end
    for (int i = 0; i < ec.size(); i++) begin
      checks++;
      if (qc[i] !== ec[i] || qp0[i] !== ep0[i] || qp1[i] !== ep1[i] || qerr[i] !== eerr[i]) begin
        failures++;
        $display("FAIL mism[%0d] got %h %h %h err=%b exp %h %h %h err=%b", i,
                 qc[i], qp0[i], qp1[i], qerr[i], ec[i], ep0[i], ep1[i], eerr[i]);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL mism_sticky got err=%b exp 1", error); end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    checks++;
    if (error !== 1'b0 || match_count !== 16'd0 || coord_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush got err=%b cnt=%0d v=%b exp 0 0 0", error, match_count, coord_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    clr(); add_isect(); add_isect(); run(300, 0, 0);
    checks++;
    if (timed_out || qc.size() != ec.size() || qp0.size() != ep0.size() || qp1.size() != ep1.size()) begin
      failures++;
      $display("FAIL b2b_len got %0d/%0d/%0d timeout=%b exp %0d", qc.size(), qp0.size(), qp1.size(), timed_out, ec.size());
    end
    for (int i = 0; i < ec.size(); i++) begin
      checks++;
      if (qc[i] !== ec[i] || qp0[i] !== ep0[i] || qp1[i] !== ep1[i] || qcnt[i] != ecnt[i]) begin
        failures++;
        $display("FAIL b2b[%0d] got %h %h %h cnt=%0d exp %h %h %h cnt=%0d", i,
                 qc[i], qp0[i], qp1[i], qcnt[i], ec[i], ep0[i], ep1[i], ecnt[i]);
      end
    end
  endtask

  task automatic test_tile_en();
    @(posedge clk); #1;
    coord_in_0 = 17'd9; pos_in_0 = 17'd1; coord_in_1 = 17'd9; pos_in_1 = 17'd2;
    coord_in_0_valid = 1; pos_in_0_valid = 1; coord_in_1_valid = 1; pos_in_1_valid = 1;
    tile_en = 0;
    #1;
    checks++;
    if ({coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready} !== 4'b0) begin
      failures++;
      $display("FAIL tile_ready got %b%b%b%b exp 0000", coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (coord_out_valid !== 1'b0 || match_count !== 16'd0) begin
      failures++;
      $display("FAIL tile_hold got v=%b cnt=%0d exp 0 0", coord_out_valid, match_count);
    end
    idle_inputs(); tile_en = 1;
  endtask

  task automatic test_reset_mid();
    clr();
    @(posedge clk); #1;
    coord_in_0 = 17'd3; pos_in_0 = 17'd11; coord_in_1 = 17'd3; pos_in_1 = 17'd20;
    coord_in_0_valid = 1; pos_in_0_valid = 1; coord_in_1_valid = 1; pos_in_1_valid = 1;
    coord_out_ready = 0; pos_out_0_ready = 1; pos_out_1_ready = 1;
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (coord_out_valid !== 1'b1 || coord_out !== 17'd3 || match_count !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_pending got v=%b c=%h cnt=%0d exp 1 00003 1", coord_out_valid, coord_out, match_count);
    end
    #2 rst_n = 1;
    #1;
    checks++;
    if ({coord_out_valid, pos_out_0_valid, pos_out_1_valid} !== 3'b0 || match_count !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_async got v=%b%b%b cnt=%0d exp 000 0", coord_out_valid, pos_out_0_valid, pos_out_1_valid, match_count);
    end
    @(posedge clk); #1;
    rst_n = 0;
    add_isect(); run(200, 0, 0);
    checks++;
    if (timed_out || qc.size() != ec.size() || qp0.size() != ep0.size() || qp1.size() != ep1.size()) begin
      failures++;
      $display("FAIL rstmid_len got %0d/%0d/%0d timeout=%b exp %0d", qc.size(), qp0.size(), qp1.size(), timed_out, ec.size());
    end
    for (int i = 0; i < ec.size(); i++) begin
      checks++;
      if (qc[i] !== ec[i] || qp0[i] !== ep0[i] || qp1[i] !== ep1[i] || qcnt[i] != ecnt[i]) begin
        failures++;
        $display("FAIL rstmid[%0d] got %h %h %h cnt=%0d exp %h %h %h cnt=%0d", i,
                 qc[i], qp0[i], qp1[i], qcnt[i], ec[i], ep0[i], ep1[i], ecnt[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      rst_n = 1;
      @(posedge clk); #1;
      rst_n = 0;
      clr(); add_rand(3, 0); add_rand(2, t[0]);
      run(4000, t[1], 1'b1);
      checks++;
      if (timed_out || qc.size() != ec.size() || qp0.size() != ep0.size() || qp1.size() != ep1.size()) begin
        failures++;
        $display("FAIL rand%0d_len got %0d/%0d/%0d timeout=%b exp %0d", t, qc.size(), qp0.size(), qp1.size(), timed_out, ec.size());
      end
      for (int i = 0; i < ec.size(); i++) begin
        checks++;
        if (qc[i] !== ec[i] || qp0[i] !== ep0[i] || qp1[i] !== ep1[i] || qcnt[i] != ecnt[i] || qerr[i] !== eerr[i]) begin
          failures++;
          $display("FAIL rand%0d[%0d] got %h %h %h cnt=%0d err=%b exp %h %h %h cnt=%0d err=%b", t, i,
                   qc[i], qp0[i], qp1[i], qcnt[i], qerr[i], ec[i], ep0[i], ep1[i], ecnt[i], eerr[i]);
        end
      end
      checks++;
      if (stall_viol != 0 || pair_viol != 0) begin
        failures++;
        $display("FAIL rand%0d_stall got stall_viol=%0d pair_viol=%0d exp 0 0", t, stall_viol, pair_viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_intersection();
    test_empty();
    test_skewed();
    test_stop_mismatch();
    test_back_to_back();
    test_tile_en();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
